// File: rtl/amiq_mux_sched.sv
// amiq_mux_sched: cycle-exact replay of three (value, delay) queues onto the amiq_mux2_1 inputs.
// Latency: start sampled at edge T, first values after T+1, done one cycle after the last hold expires.
// Backpressure: wr_ready low while the target queue is full; AMIQ_MUX_SCHED_ERR_EN compiles in err.

// Per-channel entry queue with registered pointers and occupancy.
// Latency: head_dat is valid combinationally from the read pointer; push visible next cycle.
// Backpressure: full blocks push, empty blocks pop; same-cycle push and pop keep occupancy.
module amiq_mux_sched_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is not reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
endmodule

module amiq_mux_sched #(
    parameter int DEPTH   = 8,
    parameter int DELAY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [1:0]         wr_chan,
    input  logic               wr_value,
    input  logic [DELAY_W-1:0] wr_delay,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               in0,
    output logic               in1,
    output logic               sel,
    output logic               err
);
    typedef struct packed {
        logic               value;
        logic [DELAY_W-1:0] delay;
    } entry_t;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam int         NCH       = 3;
    localparam logic [1:0] CHAN_NONE = 2'd3;

    state_t             state;
    state_t             state_nxt;
    entry_t             wr_entry;
    entry_t             head [NCH];
    logic [DELAY_W-1:0] hold [NCH];
    logic [NCH-1:0]     q_full;
    logic [NCH-1:0]     q_empty;
    logic [NCH-1:0]     push;
    logic [NCH-1:0]     pop;
    logic [NCH-1:0]     active;
    logic [NCH-1:0]     active_nxt;
    logic [NCH-1:0]     chan_out;
    logic               empty_start;
    logic               done_q;

    assign wr_entry = {wr_value, wr_delay};

    always_comb begin
        wr_ready = 1'b1;
        push     = '0;
        for (int c = 0; c < NCH; c++) begin
            if (wr_chan == 2'(c)) begin
                wr_ready = !q_full[c];
                push[c]  = wr_valid && !q_full[c];
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        amiq_mux_sched_fifo #(
            .DEPTH (DEPTH),
            .W     ($bits(entry_t))
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push[c]),
            .push_dat (wr_entry),
            .pop      (pop[c]),
            .head_dat (head[c]),
            .full     (q_full[c]),
            .empty    (q_empty[c])
        );
    end

    // Pop when the hold expires this cycle so the next entry follows with no gap.
    always_comb begin
        pop        = '0;
        active_nxt = active;
        for (int c = 0; c < NCH; c++) begin
            if (state == IDLE && start) begin
                active_nxt[c] = !q_empty[c];
            end else if (active[c] && (hold[c] == '0 || hold[c] == DELAY_W'(1))) begin
                pop[c]        = !q_empty[c];
                active_nxt[c] = !q_empty[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= '0;
            chan_out <= '0;
            for (int c = 0; c < NCH; c++) hold[c] <= '0;
        end else begin
            active <= active_nxt;
            for (int c = 0; c < NCH; c++) begin
                if (pop[c]) begin
                    chan_out[c] <= head[c].value;
                    hold[c]     <= (head[c].delay == '0) ? DELAY_W'(1) : head[c].delay;
                end else if (hold[c] != '0) begin
                    hold[c] <= hold[c] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && active_nxt != '0) state_nxt = RUN;
            RUN:     if (active_nxt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // An empty start stays in IDLE but still answers with a done pulse one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            empty_start <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            empty_start <= (state == IDLE) && start && (&q_empty);
            done_q      <= (state_nxt == DONE) || empty_start;
        end
    end

    always_comb begin
        busy = (state == RUN);
        done = done_q;
    end

    assign in0 = chan_out[0];
    assign in1 = chan_out[1];
    assign sel = chan_out[2];

`ifdef AMIQ_MUX_SCHED_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((wr_valid && wr_chan == CHAN_NONE) ||
                     (start && state == RUN) ||
                     (wr_valid && !wr_ready)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_amiq_mux_sched.sv
// Directed bench for amiq_mux_sched: replay timing, channel independence, full queue, empty start,
// appends during a run, and reset in the middle of a run.
module tb_amiq_mux_sched;
    localparam int DEPTH   = 8;
    localparam int DELAY_W = 8;
`ifdef AMIQ_MUX_SCHED_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_valid;
    logic               wr_ready;
    logic [1:0]         wr_chan;
    logic               wr_value;
    logic [DELAY_W-1:0] wr_delay;
    logic               start;
    logic               busy;
    logic               done;
    logic               in0;
    logic               in1;
    logic               sel;
    logic               err;
    logic [7:0]         pat;
    int                 tests = 0;
    int                 fails = 0;

    always #5 clk = ~clk;

    amiq_mux_sched #(
        .DEPTH   (DEPTH),
        .DELAY_W (DELAY_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_chan  (wr_chan),
        .wr_value (wr_value),
        .wr_delay (wr_delay),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .in0      (in0),
        .in1      (in1),
        .sel      (sel),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic v, input logic [DELAY_W-1:0] d);
        wr_valid = 1'b1;
        wr_chan  = ch;
        wr_value = v;
        wr_delay = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_chan  = 2'd0;
        wr_value = 1'b0;
        wr_delay = '0;
        start    = 1'b0;
        pat      = 8'b1011_0010;

        // Reset state
        tick();
        chk("rst_in0", in0, 0);
        chk("rst_in1", in1, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_ready", wr_ready, 1);
        tick();
        rst = 1'b0;
        tick();

        // Basic replay: in0 (1,3),(0,2); a start during RUN is ignored
        wr(2'd0, 1'b1, 8'd3);
        wr(2'd0, 1'b0, 8'd2);
        go();
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("basic_in0", in0, (k <= 3) ? 1 : 0);
            chk("basic_busy", busy, (k <= 5) ? 1 : 0);
            chk("basic_done", done, (k == 6) ? 1 : 0);
            start = (k == 2);
        end
        start = 1'b0;
        chk("start_in_run_err", err, ERR_ON);

        // Independent channels: sel (1,0),(0,5), in1 (1,2)
        wr(2'd2, 1'b1, 8'd0);
        wr(2'd2, 1'b0, 8'd5);
        wr(2'd1, 1'b1, 8'd2);
        go();
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("indep_sel", sel, (k == 1) ? 1 : 0);
            chk("indep_in1", in1, 1);
            chk("indep_busy", busy, (k <= 6) ? 1 : 0);
            chk("indep_done", done, (k == 7) ? 1 : 0);
        end

        // Empty start: done one cycle later, busy never rises
        go();
        chk("empty_busy_t0", busy, 0);
        chk("empty_done_t0", done, 0);
        tick();
        chk("empty_done_t1", done, 1);
        chk("empty_busy_t1", busy, 0);
        chk("empty_in1_kept", in1, 1);
        tick();
        chk("empty_done_t2", done, 0);

        // Full queue: 8 accepted, 9th refused
        wr_chan  = 2'd0;
        wr_delay = 8'd1;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_value = pat[i];
            #1;
            chk("fill_ready", wr_ready, 1);
            tick();
        end
        wr_value = 1'b1;
        #1;
        chk("full_ready", wr_ready, 0);
        tick();
        wr_valid = 1'b0;
        chk("full_err", err, ERR_ON);
        wr_chan = 2'd3;
        #1;
        chk("chan3_ready", wr_ready, 1);
        wr_chan = 2'd1;
        #1;
        chk("other_ready", wr_ready, 1);
        wr_chan = 2'd0;
        go();
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k <= 8) chk("full_replay_in0", in0, pat[k-1]);
            chk("full_replay_done", done, (k == 9) ? 1 : 0);
        end

        // Append during run, late write to idle in0, write at in1 finishing cycle
        wr(2'd1, 1'b0, 8'd4);
        go();
        tick();
        chk("app_in1_t1", in1, 0);
        wr_valid = 1'b1;
        wr_chan  = 2'd1;
        wr_value = 1'b1;
        wr_delay = 8'd1;
        tick();
        chk("app_in1_t2", in1, 0);
        wr_chan  = 2'd0;
        wr_value = 1'b0;
        wr_delay = 8'd2;
        tick();
        wr_valid = 1'b0;
        chk("app_in1_t3", in1, 0);
        chk("late_in0_t3", in0, 1);
        tick();
        chk("app_in1_t4", in1, 0);
        tick();
        chk("app_in1_t5", in1, 1);
        chk("app_done_t5", done, 0);
        wr_valid = 1'b1;
        wr_chan  = 2'd1;
        wr_value = 1'b0;
        wr_delay = 8'd1;
        tick();
        wr_valid = 1'b0;
        chk("app_done_t6", done, 1);
        chk("finish_write_not_replayed", in1, 1);
        chk("late_in0_t6", in0, 1);
        tick();
        go();
        tick();
        chk("late_in0_run2_t1", in0, 0);
        chk("finish_write_run2_in1", in1, 0);
        tick();
        chk("late_in0_run2_t2", in0, 0);
        chk("late_done_run2_t2", done, 0);
        tick();
        chk("late_done_run2_t3", done, 1);

        // Reset mid-run
        tick();
        wr(2'd0, 1'b1, 8'd5);
        wr(2'd2, 1'b1, 8'd5);
        wr(2'd1, 1'b1, 8'd3);
        go();
        tick();
        chk("mid_in0_t1", in0, 1);
        chk("mid_sel_t1", sel, 1);
        chk("mid_in1_t1", in1, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_in0", in0, 0);
        chk("mid_rst_in1", in1, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_no_done", done, 0);
            chk("mid_no_busy", busy, 0);
        end
        wr(2'd3, 1'b1, 8'd1);
        chk("chan3_err", err, ERR_ON);
        go();
        tick();
        chk("flushed_done", done, 1);
        chk("flushed_busy", busy, 0);
        chk("flushed_in0", in0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
